pmem_arbiter: RTL and testbench

//  Two-to-one arbiter between the instruction cache (fetch side, mem port 1) and the data

---
 rtl/lc3b_types.sv | 24 ++
 rtl/pmem_arbiter_if.sv | 46 ++++
 rtl/pmem_arbiter_ctrl.sv | 96 +++++++++
 rtl/pmem_arbiter.sv | 90 +++++++++
 tb/tb_pmem_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word/line typedefs, line geometry, pmem op codes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lc3b_types;

  localparam int LC3B_WORD_WIDTH  = 16;
  localparam int LC3B_LINE_WIDTH  = 128;
  localparam int LC3B_LINE_OFFSET = 4;

  typedef logic [LC3B_WORD_WIDTH-1:0] lc3b_word;
  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_line;

  typedef enum logic [1:0] {
    PMEM_NONE,
    PMEM_READ,
    PMEM_WRITE
  } lc3b_pmem_op;

  // Clear the byte-within-line offset so memory always sees a line address.
  function automatic lc3b_word line_align(input lc3b_word addr);
    return {addr[LC3B_WORD_WIDTH-1:LC3B_LINE_OFFSET], {LC3B_LINE_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory line ports around the arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are levels held until the matching resp pulse.
interface pmem_arbiter_if;
  import lc3b_types::*;

  logic     icache_pmem_read;
  lc3b_word icache_pmem_address;
  lc3b_line icache_pmem_rdata;
  logic     icache_pmem_resp;

  logic     dcache_pmem_read;
  logic     dcache_pmem_write;
  lc3b_word dcache_pmem_address;
  lc3b_line dcache_pmem_wdata;
  lc3b_line dcache_pmem_rdata;
  logic     dcache_pmem_resp;

  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_address;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic     pmem_resp;

  // Arbiter side.
  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Requester/memory side.
  modport master (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/pmem_arbiter_ctrl.sv
// Grant FSM for the pmem arbiter: D priority with a starvation guard for I.
// Latency: grant decided combinationally in IDLE, takes effect on the next edge.
// Backpressure: one transaction in flight; IDLE turnaround cycle after every resp.
module pmem_arbiter_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic pmem_resp_i,
  output logic grant_i_o,
  output logic grant_d_o,
  output logic serve_i_o,
  output logic serve_d_o
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       d_wins;

  // D wins unless I is waiting and has already lost LIMIT times in a row.
  assign d_wins = d_req_i && (!i_req_i || (starve_q < LIMIT));

  // State and starve counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state: pick a winner from IDLE, return to IDLE on the memory response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d = SERVE_D;
        end else if (i_req_i) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: one-cycle grant strobes in IDLE, serve flags while a transaction is open.
  always_comb begin
    grant_i_o = 1'b0;
    grant_d_o = 1'b0;
    serve_i_o = 1'b0;
    serve_d_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          grant_d_o = 1'b1;
        end else if (i_req_i) begin
          grant_i_o = 1'b1;
        end
      end
      SERVE_I: serve_i_o = 1'b1;
      SERVE_D: serve_d_o = 1'b1;
      default: ;
    endcase
  end

  // Starve counter: count D wins over a waiting I (saturating), clear on any other grant.
  always_comb begin
    starve_d = starve_q;
    if (grant_d_o && i_req_i) begin
      if (starve_q < LIMIT) begin
        starve_d = starve_q + 4'd1;
      end
    end else if (grant_d_o || grant_i_o) begin
      starve_d = 4'd0;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Two-to-one I/D cache arbiter in front of the single pmem line port.
// Latency: request seen in IDLE drives pmem_read/write next cycle; resp forwarded same cycle.
// Backpressure: winner held until pmem_resp; loser waits; requester inputs ignored while serving.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  pmem_arbiter_if.slave   bus
);

  logic        grant_i, grant_d, serve_i, serve_d, busy;
  logic        d_req;
  lc3b_word    addr_q, addr_d;
  lc3b_line    wdata_q, wdata_d;
  lc3b_pmem_op op_q, op_d;

  assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  pmem_arbiter_ctrl #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_req_i     (bus.icache_pmem_read),
    .d_req_i     (d_req),
    .pmem_resp_i (bus.pmem_resp),
    .grant_i_o   (grant_i),
    .grant_d_o   (grant_d),
    .serve_i_o   (serve_i),
    .serve_d_o   (serve_d)
  );

  // Capture the winner's line address, op and write data on its grant edge.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    if (grant_d) begin
      addr_d = line_align(bus.dcache_pmem_address);
      if (bus.dcache_pmem_write) begin
        op_d    = PMEM_WRITE;
        wdata_d = bus.dcache_pmem_wdata;
      end else begin
        op_d    = PMEM_READ;
        wdata_d = '0;
      end
    end else if (grant_i) begin
      addr_d  = line_align(bus.icache_pmem_address);
      op_d    = PMEM_READ;
      wdata_d = '0;
    end
  end

  // Request latches; memory is driven only from these while a transaction is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= PMEM_NONE;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
    end
  end

  assign busy             = serve_i | serve_d;
  assign bus.pmem_read    = busy && (op_q == PMEM_READ);
  assign bus.pmem_write   = busy && (op_q == PMEM_WRITE);
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Read data is broadcast; only the current winner sees the completion pulse.
  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;
  assign bus.icache_pmem_resp  = serve_i & bus.pmem_resp;
  assign bus.dcache_pmem_resp  = serve_d & bus.pmem_resp;

  // Flag a D-cache that asks for read and write at once (write is what gets served).
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.dcache_pmem_read && bus.dcache_pmem_write))
        else $error("pmem_arbiter: dcache read and write asserted together");
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;
  import lc3b_types::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pmem_arbiter_if bus();

  pmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: who owns memory (0 none, 1 I, 2 D) and what it asked for.
  int       m_owner;
  lc3b_word m_addr;
  lc3b_line m_wdata;
  bit       m_wr;
  int       m_starve;

  // Memory model state.
  int mem_cnt, mem_lat, fixed_lat;
  bit spurious_ok;

  // Memory: fresh rdata every cycle, resp after the chosen latency, optional stray resp when idle.
  task automatic drive_mem();
    bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (m_owner != 0) begin
      mem_cnt++;
      bus.pmem_resp = (mem_cnt >= mem_lat);
    end else begin
      bus.pmem_resp = spurious_ok && ($urandom_range(0, 3) == 0);
    end
  endtask

  // Apply the arbitration rules to what the DUT samples at this edge, then cross the edge.
  task automatic tick();
    bit ip, dp;
    ip = bus.icache_pmem_read;
    dp = bus.dcache_pmem_read | bus.dcache_pmem_write;
    if (reset) begin
      m_owner = 0; m_addr = '0; m_wdata = '0; m_wr = 0; m_starve = 0;
    end else if (m_owner != 0) begin
      if (bus.pmem_resp) m_owner = 0;
    end else if (dp && (!ip || m_starve < LIMIT)) begin
      m_owner  = 2;
      m_wr     = bus.dcache_pmem_write;
      m_addr   = bus.dcache_pmem_address & 16'hFFF0;
      m_wdata  = m_wr ? bus.dcache_pmem_wdata : '0;
      m_starve = ip ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      mem_cnt  = 0;
      mem_lat  = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
    end else if (ip) begin
      m_owner  = 1;
      m_wr     = 0;
      m_addr   = bus.icache_pmem_address & 16'hFFF0;
      m_wdata  = '0;
      m_starve = 0;
      mem_cnt  = 0;
      mem_lat  = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.icache_pmem_read  = 1'b0;
    bus.dcache_pmem_read  = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    spurious_ok = 0;
    repeat (12) begin
      drive_mem();
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.icache_pmem_read = 1'b0; bus.icache_pmem_address = '0;
    bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0;
    bus.dcache_pmem_address = '0; bus.dcache_pmem_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    spurious_ok = 0; fixed_lat = 1; m_owner = 0;
    repeat (2) begin
      drive_mem();
      tick();
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_mem();
      #2;
      checks++;
      if ({bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctrl cycle %0d rd/wr/iresp/dresp=%b%b%b%b want 0000", c,
                 bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp);
      end
      checks++;
      if (bus.pmem_address !== 16'h0000 || bus.pmem_wdata !== '0) begin
        errors++;
        $display("FAIL reset_bus cycle %0d addr=%h wdata=%h want 0", c, bus.pmem_address, bus.pmem_wdata);
      end
      tick();
    end
  endtask

  task automatic test_i_read();
    int cyc;
    bit seen;
    fixed_lat = 3;
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = 16'h1236;
    drive_mem();
    #2;
    checks++;
    if (bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL i_read_same_cycle pmem_read=%b want 0", bus.pmem_read);
    end
    tick();
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 8) begin
      cyc++;
      drive_mem();
      #2;
      checks++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h1230) begin
        errors++;
        $display("FAIL i_read_bus cycle %0d rd=%b wr=%b addr=%h want 1 0 1230", cyc,
                 bus.pmem_read, bus.pmem_write, bus.pmem_address);
      end
      checks++;
      if (bus.icache_pmem_resp !== (cyc == 3) || bus.dcache_pmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL i_read_resp cycle %0d iresp=%b dresp=%b want %0d 0", cyc,
                 bus.icache_pmem_resp, bus.dcache_pmem_resp, (cyc == 3));
      end
      checks++;
      if (bus.icache_pmem_rdata !== bus.pmem_rdata || bus.dcache_pmem_rdata !== bus.pmem_rdata) begin
        errors++;
        $display("FAIL i_read_rdata cycle %0d i=%h d=%h want %h", cyc,
                 bus.icache_pmem_rdata, bus.dcache_pmem_rdata, bus.pmem_rdata);
      end
      if (bus.pmem_resp) seen = 1;
      tick();
      if (seen) bus.icache_pmem_read = 1'b0;
    end
    drive_mem();
    #2;
    checks++;
    if (bus.pmem_read !== 1'b0 || !seen) begin
      errors++;
      $display("FAIL i_read_turnaround pmem_read=%b resp_seen=%0d want 0 1", bus.pmem_read, seen);
    end
    tick();
    drain();
  endtask

  task automatic test_priority();
    bit [5:0] e_wr, e_rd, e_dr, e_ir;
    bit rel_i, rel_d;
    lc3b_line a5;
    e_wr = 6'b000011; e_rd = 6'b011000; e_dr = 6'b000010; e_ir = 6'b010000;
    a5 = {16{8'hA5}};
    fixed_lat = 2;
    bus.icache_pmem_read = 1'b1;  bus.icache_pmem_address = 16'h0040;
    bus.dcache_pmem_write = 1'b1; bus.dcache_pmem_address = 16'h8010;
    bus.dcache_pmem_wdata = a5;
    drive_mem();
    tick();
    for (int c = 0; c < 6; c++) begin
      drive_mem();
      #2;
      checks++;
      if (bus.pmem_write !== e_wr[c] || bus.pmem_read !== e_rd[c]) begin
        errors++;
        $display("FAIL prio_rw cycle %0d rd=%b wr=%b want %b %b", c + 1,
                 bus.pmem_read, bus.pmem_write, e_rd[c], e_wr[c]);
      end
      checks++;
      if (bus.dcache_pmem_resp !== e_dr[c] || bus.icache_pmem_resp !== e_ir[c]) begin
        errors++;
        $display("FAIL prio_resp cycle %0d dresp=%b iresp=%b want %b %b", c + 1,
                 bus.dcache_pmem_resp, bus.icache_pmem_resp, e_dr[c], e_ir[c]);
      end
      if (e_wr[c]) begin
        checks++;
        if (bus.pmem_address !== 16'h8010 || bus.pmem_wdata !== a5) begin
          errors++;
          $display("FAIL prio_dwrite cycle %0d addr=%h wdata=%h want 8010 %h", c + 1,
                   bus.pmem_address, bus.pmem_wdata, a5);
        end
      end
      if (e_rd[c]) begin
        checks++;
        if (bus.pmem_address !== 16'h0040 || bus.pmem_wdata !== '0) begin
          errors++;
          $display("FAIL prio_iread cycle %0d addr=%h wdata=%h want 0040 0", c + 1,
                   bus.pmem_address, bus.pmem_wdata);
        end
      end
      rel_i = (m_owner == 1) && bus.pmem_resp;
      rel_d = (m_owner == 2) && bus.pmem_resp;
      tick();
      if (rel_i) bus.icache_pmem_read = 1'b0;
      if (rel_d) bus.dcache_pmem_write = 1'b0;
    end
    drain();
  endtask

  task automatic test_starvation();
    int obs[$];
    int exp_seq[6];
    bit prev_act, act;
    exp_seq[0] = 2; exp_seq[1] = 2; exp_seq[2] = 2; exp_seq[3] = 2; exp_seq[4] = 1; exp_seq[5] = 2;
    fixed_lat = 1;
    prev_act = 0;
    bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 16'h0100;
    bus.dcache_pmem_read = 1'b1;
    for (int c = 0; c < 60 && obs.size() < 6; c++) begin
      bus.dcache_pmem_address = 16'h2000 | 16'($urandom_range(0, 255) << 4);
      drive_mem();
      #2;
      act = bus.pmem_read | bus.pmem_write;
      if (act && !prev_act) obs.push_back((bus.pmem_address == 16'h0100) ? 1 : 2);
      prev_act = act;
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= obs.size()) begin
        errors++;
        $display("FAIL starve_grant %0d not seen within cycle budget, want %0d", k, exp_seq[k]);
      end else if (obs[k] != exp_seq[k]) begin
        errors++;
        $display("FAIL starve_grant %0d owner=%0d want %0d (1=I 2=D)", k, obs[k], exp_seq[k]);
      end
    end
    drain();
  endtask

  task automatic test_addr_change();
    fixed_lat = 4;
    bus.dcache_pmem_read = 1'b1;
    bus.dcache_pmem_address = 16'h2000;
    drive_mem();
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) bus.dcache_pmem_address = 16'h3000;
      drive_mem();
      #2;
      checks++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h2000) begin
        errors++;
        $display("FAIL addr_hold cycle %0d rd=%b addr=%h want 1 2000", c, bus.pmem_read, bus.pmem_address);
      end
      tick();
    end
    drive_mem();
    #2;
    checks++;
    if (bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL addr_turnaround pmem_read=%b want 0", bus.pmem_read);
    end
    tick();
    drive_mem();
    #2;
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h3000) begin
      errors++;
      $display("FAIL addr_next rd=%b addr=%h want 1 3000", bus.pmem_read, bus.pmem_address);
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    fixed_lat = 10;
    bus.dcache_pmem_write = 1'b1;
    bus.dcache_pmem_address = 16'h4448;
    bus.dcache_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
    drive_mem();
    tick();
    bus.dcache_pmem_write = 1'b0;
    drive_mem();
    #2;
    checks++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_address !== 16'h4440) begin
      errors++;
      $display("FAIL rstmid_serve wr=%b addr=%h want 1 4440", bus.pmem_write, bus.pmem_address);
    end
    tick();
    reset = 1'b1;
    drive_mem();
    #2;
    checks++;
    if (bus.pmem_write !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_sync wr=%b want 1 before the reset edge", bus.pmem_write);
    end
    tick();
    reset = 1'b0;
    drive_mem();
    #2;
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp} !== 4'b0000 ||
        bus.pmem_address !== 16'h0000 || bus.pmem_wdata !== '0) begin
      errors++;
      $display("FAIL rstmid_idle rd/wr/iresp/dresp=%b%b%b%b addr=%h want 0000 0000",
               bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp, bus.pmem_address);
    end
    tick();
    drive_mem();
    bus.pmem_resp = 1'b1;
    #2;
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_late_resp rd/wr/iresp/dresp=%b%b%b%b want 0000",
               bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp);
    end
    tick();
    drive_mem();
    #2;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after rd=%b wr=%b want 0 0", bus.pmem_read, bus.pmem_write);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    bit rel_i, rel_d, w;
    fixed_lat = 0;
    spurious_ok = 1;
    for (int n = 0; n < 400; n++) begin
      if (!bus.icache_pmem_read && $urandom_range(0, 2) == 0) begin
        bus.icache_pmem_read = 1'b1;
        bus.icache_pmem_address = 16'($urandom);
      end else if (m_owner == 1 && $urandom_range(0, 3) == 0) begin
        bus.icache_pmem_address = 16'($urandom);
      end
      if (!(bus.dcache_pmem_read || bus.dcache_pmem_write) && $urandom_range(0, 2) == 0) begin
        w = 1'($urandom);
        bus.dcache_pmem_read = !w;
        bus.dcache_pmem_write = w;
        bus.dcache_pmem_address = 16'($urandom);
        bus.dcache_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if (m_owner == 2 && $urandom_range(0, 3) == 0) begin
        w = 1'($urandom);
        bus.dcache_pmem_read = !w;
        bus.dcache_pmem_write = w;
        bus.dcache_pmem_address = 16'($urandom);
        bus.dcache_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      drive_mem();
      #2;
      checks++;
      if (bus.pmem_read !== (m_owner != 0 && !m_wr) || bus.pmem_write !== (m_owner != 0 && m_wr)) begin
        errors++;
        $display("FAIL rand_rw n=%0d rd=%b wr=%b want %0d %0d", n, bus.pmem_read, bus.pmem_write,
                 (m_owner != 0 && !m_wr), (m_owner != 0 && m_wr));
      end
      checks++;
      if (bus.pmem_address !== m_addr || bus.pmem_wdata !== m_wdata) begin
        errors++;
        $display("FAIL rand_bus n=%0d addr=%h wdata=%h want %h %h", n, bus.pmem_address, bus.pmem_wdata,
                 m_addr, m_wdata);
      end
      checks++;
      if (bus.icache_pmem_resp !== (m_owner == 1 && bus.pmem_resp) ||
          bus.dcache_pmem_resp !== (m_owner == 2 && bus.pmem_resp)) begin
        errors++;
        $display("FAIL rand_resp n=%0d iresp=%b dresp=%b want %0d %0d", n, bus.icache_pmem_resp,
                 bus.dcache_pmem_resp, (m_owner == 1 && bus.pmem_resp), (m_owner == 2 && bus.pmem_resp));
      end
      checks++;
      if (bus.icache_pmem_rdata !== bus.pmem_rdata || bus.dcache_pmem_rdata !== bus.pmem_rdata) begin
        errors++;
        $display("FAIL rand_rdata n=%0d i=%h d=%h want %h", n, bus.icache_pmem_rdata,
                 bus.dcache_pmem_rdata, bus.pmem_rdata);
      end
      rel_i = (m_owner == 1) && bus.pmem_resp;
      rel_d = (m_owner == 2) && bus.pmem_resp;
      tick();
      if (rel_i) bus.icache_pmem_read = 1'b0;
      if (rel_d) begin
        bus.dcache_pmem_read = 1'b0;
        bus.dcache_pmem_write = 1'b0;
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_priority();
    test_starvation();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
